// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-lite constants and arbiter state encoding for the bridge front-end.
// DRAIN exists only when ARB_TIMEOUT_EN is defined.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
`ifdef ARB_TIMEOUT_EN
    , ST_DRAIN
`endif
  } arb_state_e;

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Requester req/done channels plus the AHB-lite bridge slave port.
// master = arbiter view, slave = requesters/bridge view.
interface ahb_bridge_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req0,   req1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic              write0, write1;
  logic [2:0]        size0,  size1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0,  done1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0,   err1;

  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    input  req0, req1, addr0, addr1, write0, write1, size0, size1, wdata0, wdata1,
    output done0, done1, rdata0, rdata1, err0, err1,
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    output req0, req1, addr0, addr1, write0, write1, size0, size1, wdata0, wdata1,
    input  done0, done1, rdata0, rdata1, err0, err1,
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_bridge_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester not
// granted last time wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    grant_o = req1_i;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Shares the AHB-to-APB bridge slave port between two req/done requesters,
// one single NONSEQ transfer at a time. Optional macro: ARB_TIMEOUT_EN.
module ahb_bridge_arbiter
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_bridge_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic              last_q,  last_d;
  logic              gnt_q,   gnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q,  size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic              pick;
  logic              pick_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  rr_arb2 u_rr (
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .last_grant_i(last_q),
    .grant_o     (pick),
    .valid_o     (pick_valid)
  );

  assign bus.HREADY = bus.HREADYOUT;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif

    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = '0;
    bus.HWDATA = '0;
    bus.done0  = 1'b0;
    bus.done1  = 1'b0;
    bus.rdata0 = '0;
    bus.rdata1 = '0;
    bus.err0   = 1'b0;
    bus.err1   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          write_d = pick ? bus.write1 : bus.write0;
          size_d  = pick ? bus.size1  : bus.size0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HADDR  = addr_q;
        bus.HWRITE = write_q;
        bus.HSIZE  = size_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = '0;
        tmo_d      = 1'b0;
`endif
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        bus.HWDATA = wdata_q;
        if (bus.HREADYOUT) begin
          rdata_d = write_q ? '0 : bus.HRDATA;
          err_d   = bus.HRESP;
          state_d = ST_DONE;
        end
`ifdef ARB_TIMEOUT_EN
        // Counter holds cycles already waited; the last allowed one forces an error completion.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = HRESP_ERROR;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        if (gnt_q) begin
          bus.done1  = 1'b1;
          bus.rdata1 = rdata_q;
          bus.err1   = err_q;
        end else begin
          bus.done0  = 1'b1;
          bus.rdata0 = rdata_q;
          bus.err0   = err_q;
        end
        last_d  = gnt_q;
`ifdef ARB_TIMEOUT_EN
        state_d = tmo_q ? ST_DRAIN : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end

`ifdef ARB_TIMEOUT_EN
      ST_DRAIN: begin
        if (bus.HREADYOUT) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed-vector bench: per-cycle stimulus and expectation tables built from a
// transaction timeline model, checked every cycle plus literal pins.
module tb_ahb_bridge_arbiter;

  localparam int N   = 84;
  localparam int TMO = 8;

  logic clk;
  logic rstn;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  ahb_bridge_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_bridge_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK   (clk),
    .HRESETn(rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus tables, indexed [requester][cycle] or [cycle]
  logic        req_s [2][N];
  logic        wr_s  [2][N];
  logic [31:0] adr_s [2][N];
  logic [2:0]  sz_s  [2][N];
  logic [31:0] wd_s  [2][N];
  logic        rdy_s [N];
  logic        resp_s[N];
  logic [31:0] hrd_s [N];
  logic        rstn_s[N];

  // expectation tables
  logic        e_hsel  [N];
  logic [1:0]  e_htrans[N];
  logic [31:0] e_haddr [N];
  logic        e_hwrite[N];
  logic [2:0]  e_hsize [N];
  logic [31:0] e_hwdata[N];
  logic        e_done  [2][N];
  logic [31:0] e_rdata [2][N];
  logic        e_err   [2][N];

  task automatic init_tables();
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < 2; w++) begin
        req_s[w][k] = 1'b0; wr_s[w][k] = 1'b0; adr_s[w][k] = '0;
        sz_s[w][k]  = '0;   wd_s[w][k] = '0;
        e_done[w][k] = 1'b0; e_rdata[w][k] = '0; e_err[w][k] = 1'b0;
      end
      rdy_s[k]  = 1'b1;
      resp_s[k] = 1'b0;
      hrd_s[k]  = 32'hBAD0_0000 + 32'(k);
      rstn_s[k] = 1'b1;
      e_hsel[k] = 1'b0; e_htrans[k] = 2'b00; e_haddr[k] = '0;
      e_hwrite[k] = 1'b0; e_hsize[k] = '0; e_hwdata[k] = '0;
    end
  endtask

  task automatic drive_req(input int who, input int from, input int to, input logic w,
                           input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    for (int k = from; k <= to; k++) begin
      req_s[who][k] = 1'b1; wr_s[who][k] = w; adr_s[who][k] = a;
      sz_s[who][k] = s;     wd_s[who][k] = wd;
    end
  endtask

  // A transfer sampled in IDLE cycle g: address phase g+1, data phase g+2 plus waits,
  // completion pulse the cycle after the bridge reports ready.
  task automatic plan_xfer(input int who, input int g, input int waits, input logic w,
                           input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                           input logic resp, input logic [31:0] rd);
    int r;
    e_hsel[g+1] = 1'b1; e_htrans[g+1] = 2'b10; e_haddr[g+1] = a;
    e_hwrite[g+1] = w;  e_hsize[g+1] = s;
    r = g + 2 + waits;
    for (int k = g + 2; k <= r; k++) e_hwdata[k] = wd;
    for (int k = g + 2; k < r; k++) rdy_s[k] = 1'b0;
    rdy_s[r] = 1'b1; resp_s[r] = resp; hrd_s[r] = rd;
    e_done[who][r+1]  = 1'b1;
    e_rdata[who][r+1] = w ? 32'h0 : rd;
    e_err[who][r+1]   = resp;
  endtask

  task automatic plan_timeout(input int who, input int g, input int drain_end,
                              input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    e_hsel[g+1] = 1'b1; e_htrans[g+1] = 2'b10; e_haddr[g+1] = a;
    e_hwrite[g+1] = 1'b0; e_hsize[g+1] = s;
    for (int k = g + 2; k <= g + 1 + TMO; k++) e_hwdata[k] = wd;
    for (int k = g + 2; k <= drain_end; k++) rdy_s[k] = 1'b0;
    e_done[who][g+2+TMO] = 1'b1;
    e_err[who][g+2+TMO]  = 1'b1;
  endtask

  task automatic model_reset(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      e_hsel[k] = 1'b0; e_htrans[k] = 2'b00; e_haddr[k] = '0;
      e_hwrite[k] = 1'b0; e_hsize[k] = '0; e_hwdata[k] = '0;
      for (int w = 0; w < 2; w++) begin
        e_done[w][k] = 1'b0; e_rdata[w][k] = '0; e_err[w][k] = 1'b0;
      end
    end
  endtask

  task automatic build_schedule();
    init_tables();
    rstn_s[0] = 1'b0; rstn_s[1] = 1'b0;
    // single write, zero wait
    drive_req(0, 3, 6, 1'b1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF);
    plan_xfer(0, 3, 0, 1'b1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678);
    // read with two wait states
    drive_req(1, 9, 14, 1'b0, 32'h0000_2000, 3'd2, 32'h0);
    plan_xfer(1, 9, 2, 1'b0, 32'h0000_2000, 3'd2, 32'h0, 1'b0, 32'hA5A5_A5A5);
    // both requesters continuously pending: 0,1,0,1
    drive_req(0, 17, 33, 1'b1, 32'h0000_3000, 3'd2, 32'h0A0A_0A0A);
    drive_req(1, 17, 33, 1'b0, 32'h0000_4000, 3'd1, 32'h2222_2222);
    plan_xfer(0, 17, 0, 1'b1, 32'h0000_3000, 3'd2, 32'h0A0A_0A0A, 1'b0, 32'hC0DE_0000);
    plan_xfer(1, 21, 1, 1'b0, 32'h0000_4000, 3'd1, 32'h2222_2222, 1'b0, 32'hC0DE_0001);
    plan_xfer(0, 26, 0, 1'b1, 32'h0000_3000, 3'd2, 32'h0A0A_0A0A, 1'b0, 32'hC0DE_0002);
    plan_xfer(1, 30, 0, 1'b0, 32'h0000_4000, 3'd1, 32'h2222_2222, 1'b0, 32'hC0DE_0003);
    // error response on a write
    drive_req(0, 36, 39, 1'b1, 32'h0000_1004, 3'd2, 32'h5555_AAAA);
    plan_xfer(0, 36, 0, 1'b1, 32'h0000_1004, 3'd2, 32'h5555_AAAA, 1'b1, 32'h0);
    // reset asserted during the data phase abandons the transfer
    drive_req(1, 42, 45, 1'b0, 32'h0000_2004, 3'd2, 32'h1111_1111);
    plan_xfer(1, 42, 2, 1'b0, 32'h0000_2004, 3'd2, 32'h1111_1111, 1'b0, 32'h7777_7777);
    rstn_s[45] = 1'b0;
    model_reset(46, 47);
    // after reset req0 wins the tie again
    drive_req(0, 48, 51, 1'b0, 32'h0000_5000, 3'd2, 32'h0);
    drive_req(1, 48, 55, 1'b0, 32'h0000_6000, 3'd0, 32'h0);
    plan_xfer(0, 48, 0, 1'b0, 32'h0000_5000, 3'd2, 32'h0, 1'b0, 32'h0F0F_0F0F);
    plan_xfer(1, 52, 0, 1'b0, 32'h0000_6000, 3'd0, 32'h0, 1'b0, 32'h0000_00EE);
`ifdef ARB_TIMEOUT_EN
    drive_req(0, 58, 68, 1'b0, 32'h0000_7000, 3'd2, 32'h0);
    plan_timeout(0, 58, 71, 32'h0000_7000, 3'd2, 32'h0);
    drive_req(1, 62, 76, 1'b0, 32'h0000_7100, 3'd2, 32'h0);
    plan_xfer(1, 73, 0, 1'b0, 32'h0000_7100, 3'd2, 32'h0, 1'b0, 32'h3C3C_3C3C);
`endif
  endtask

  task automatic apply(input int k);
    rstn          = rstn_s[k];
    bus.req0      = req_s[0][k]; bus.req1   = req_s[1][k];
    bus.addr0     = adr_s[0][k]; bus.addr1  = adr_s[1][k];
    bus.write0    = wr_s[0][k];  bus.write1 = wr_s[1][k];
    bus.size0     = sz_s[0][k];  bus.size1  = sz_s[1][k];
    bus.wdata0    = wd_s[0][k];  bus.wdata1 = wd_s[1][k];
    bus.HREADYOUT = rdy_s[k];
    bus.HRESP     = resp_s[k];
    bus.HRDATA    = hrd_s[k];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      chk("hsel",   32'(bus.HSEL),   32'(e_hsel[cyc]));
      chk("htrans", 32'(bus.HTRANS), 32'(e_htrans[cyc]));
      chk("haddr",  bus.HADDR,       e_haddr[cyc]);
      chk("hwrite", 32'(bus.HWRITE), 32'(e_hwrite[cyc]));
      chk("hsize",  32'(bus.HSIZE),  32'(e_hsize[cyc]));
      chk("hwdata", bus.HWDATA,      e_hwdata[cyc]);
      chk("hready", 32'(bus.HREADY), 32'(rdy_s[cyc]));
      chk("done0",  32'(bus.done0),  32'(e_done[0][cyc]));
      chk("done1",  32'(bus.done1),  32'(e_done[1][cyc]));
      chk("rdata0", bus.rdata0,      e_rdata[0][cyc]);
      chk("rdata1", bus.rdata1,      e_rdata[1][cyc]);
      chk("err0",   32'(bus.err0),   32'(e_err[0][cyc]));
      chk("err1",   32'(bus.err1),   32'(e_err[1][cyc]));

      if (cyc == 1)  chk("lit_rst_htrans", 32'(bus.HTRANS), 32'h0);
      if (cyc == 4)  chk("lit_t1_haddr",   bus.HADDR,       32'h0000_1000);
      if (cyc == 4)  chk("lit_t1_hwrite",  32'(bus.HWRITE), 32'h1);
      if (cyc == 5)  chk("lit_t1_hwdata",  bus.HWDATA,      32'hDEAD_BEEF);
      if (cyc == 6)  chk("lit_t1_done0",   32'(bus.done0),  32'h1);
      if (cyc == 14) chk("lit_t2_rdata1",  bus.rdata1,      32'hA5A5_A5A5);
      if (cyc == 14) chk("lit_t2_done0",   32'(bus.done0),  32'h0);
      if (cyc == 18) chk("lit_rr_addr_a",  bus.HADDR,       32'h0000_3000);
      if (cyc == 22) chk("lit_rr_addr_b",  bus.HADDR,       32'h0000_4000);
      if (cyc == 27) chk("lit_rr_addr_c",  bus.HADDR,       32'h0000_3000);
      if (cyc == 31) chk("lit_rr_addr_d",  bus.HADDR,       32'h0000_4000);
      if (cyc == 39) chk("lit_t4_err0",    32'(bus.err0),   32'h1);
      if (cyc == 46) chk("lit_rst_hwdata", bus.HWDATA,      32'h0);
      if (cyc == 47) chk("lit_rst_nodone", 32'(bus.done1),  32'h0);
      if (cyc == 49) chk("lit_rst_tie0",   bus.HADDR,       32'h0000_5000);
`ifdef ARB_TIMEOUT_EN
      if (cyc == 68) chk("lit_tmo_done0",  32'(bus.done0),  32'h1);
      if (cyc == 68) chk("lit_tmo_err0",   32'(bus.err0),   32'h1);
      if (cyc == 72) chk("lit_drain_hsel", 32'(bus.HSEL),   32'h0);
      if (cyc == 74) chk("lit_tmo_grant1", bus.HADDR,       32'h0000_7100);
`endif
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    build_schedule();
    apply(0);
    while (cyc < N - 1) begin
      @(posedge clk);
      #1;
      cyc++;
      apply(cyc);
    end
    @(posedge clk);
    #1;
    cyc = N;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_bridge_arbiter.md
Name: ahb_bridge_arbiter

Overview:
- Round-robin arbiter that shares the single AHB-lite slave port of the AHB-to-APB bridge between two on-chip requesters (e.g. CPU-side master and DMA engine).
- Converts each requester's simple req/done transfer interface into one AHB-lite single NONSEQ transfer.
- Waits out the bridge's wait states and returns read data and response to the granted requester.
- Sits directly in front of the bridge's HSEL/HADDR/HTRANS inputs.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 64, data-phase wait limit (used only with ARB_TIMEOUT_EN)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset; one clock; reset is synchronous and active-low
- req0 / req1  in  1  transfer request, level, held until matching done
- addr0 / addr1  in  ADDR_W  transfer address
- write0 / write1  in  1  1 = write
- size0 / size1  in  3  HSIZE encoding
- wdata0 / wdata1  in  DATA_W  write data
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid while done high
- err0 / err1  out  1  error response, valid while done high
- HSEL  out  1  bridge select
- HADDR  out  ADDR_W  bridge address
- HTRANS  out  2  bridge transfer type
- HWRITE  out  1  bridge direction
- HSIZE  out  3  bridge size
- HWDATA  out  DATA_W  bridge write data
- HREADY  out  1  combinational copy of HREADYOUT
- HRDATA  in  DATA_W  bridge read data
- HREADYOUT  in  1  bridge ready
- HRESP  in  1  bridge response, 1 = ERROR

Behaviour:
- Reset (HRESETn low at a rising edge):
  - State goes to IDLE and the last-grant pointer to 1, so req0 wins the first tie.
  - All outputs are 0: HTRANS = 00, HSEL = 0, done/err/rdata = 0.
  - Reset mid-transfer abandons the transfer with no done pulse.
- States: IDLE, ADDR, DATA, DONE, plus DRAIN with ARB_TIMEOUT_EN.
- IDLE:
  - Any req high at the edge: grant it, or grant the requester not last granted if both are high. Go to ADDR.
  - At grant, capture the granted requester's addr/write/size/wdata into internal registers. Later changes on requester inputs are ignored.
- ADDR, one cycle:
  - HSEL = 1, HTRANS = 10 (NONSEQ), HADDR/HWRITE/HSIZE driven from the captured registers.
  - Always advances to DATA.
- DATA:
  - HSEL = 0, HTRANS = 00, HWDATA = captured wdata, held stable until exit.
  - Stays in DATA while HREADYOUT = 0.
  - HREADYOUT = 1 at the edge: register HRDATA (reads only; 0 for writes) and HRESP, then go to DONE.
- DONE, one cycle:
  - done of the granted requester = 1, with rdata/err from the registered values. The other requester's outputs stay 0.
  - Update last-grant pointer, return to IDLE.
- Latency: minimum req-to-done is 3 cycles with zero wait states; each bridge wait cycle adds 1.
- Requests:
  - A requester must deassert req in the cycle after done. If req is still high in IDLE, it is a new request.
  - A req that drops before grant produces no transfer.
- Fairness: with both requests continuously high, grants alternate 0,1,0,1. There is no back-to-back pipelining; one transfer is outstanding at a time.
- HREADY = HREADYOUT combinationally at all times.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in DATA, cleared on DATA entry.
  - If HREADYOUT stays 0 for TIMEOUT_CYCLES consecutive cycles, the arbiter enters DONE with err = 1 and rdata = 0.
  - It then enters DRAIN, holding HSEL = 0 and HTRANS = 00 until HREADYOUT = 1 is sampled, then goes to IDLE. No grants are issued in DRAIN.
  - A counter width of $clog2(TIMEOUT_CYCLES+1) is sufficient.
- Disabled: no counter and no DRAIN state. DATA waits indefinitely.

Decomposition:
- Shared package ahb_bridge_pkg holds:
  - HTRANS constants: IDLE = 00, NONSEQ = 10.
  - HRESP constants: OKAY = 0, ERROR = 1.
  - The state enumeration.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_grant) giving grant index and valid.

Test Plan:
- req0 write, addr 0x0000_1000, wdata 0xDEAD_BEEF, HREADYOUT always 1 -> one NONSEQ cycle with HWRITE = 1, HWDATA = 0xDEADBEEF in the next cycle, done0 3 cycles after req, err0 = 0.
- req1 read, addr 0x0000_2000, bridge returns 0xA5A5A5A5 after 2 wait cycles -> done1 at cycle 5, rdata1 = 0xA5A5A5A5, done0 stays 0.
- req0 and req1 both asserted from reset and re-asserted after each done for 4 transfers -> grant order 0,1,0,1 and HADDR alternates between the two addresses.
- HRESP = 1 with HREADYOUT = 1 on a req0 write -> done0 with err0 = 1.
- HRESETn low during DATA -> next cycle all outputs 0, no done pulse, next req is served from IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, HREADYOUT held 0 -> done0 with err0 = 1 and rdata0 = 0 after 8 DATA cycles. A req1 pending meanwhile is granted only after HREADYOUT returns to 1.
